perceptron_comm_ctrl: RTL and testbench

- Command/response controller between the byte UART and the perceptron core, inside perceptron_top.
- Parses opcode packets arriving on the UART receive side and drives weight/input write strobes into the perceptron.
- Serialises read responses and write acknowledgements back through the UART transmit handshake.

---
 rtl/perceptron_comm_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_perceptron_comm_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_comm_ctrl.sv
// Opcode parser and response serialiser between the byte UART and the perceptron core.
// Define PERCEPTRON_COMM_TIMEOUT_EN to abort a stalled write payload after TIMEOUT_CYCLES idle clocks.
module perceptron_comm_ctrl #(
    parameter logic [7:0] OP_READ               = 8'd5,
    parameter logic [7:0] OP_WRITE_WEIGHTS      = 8'd50,
    parameter logic [7:0] OP_WRITE_INPUTS       = 8'd51,
    parameter logic [7:0] OP_READ_RESPONSE      = 8'd100,
    parameter logic [7:0] OP_WRITE_RESPONSE_OK  = 8'd101,
    parameter logic [7:0] OP_WRITE_RESPONSE_ERR = 8'd102,
    parameter int         TIMEOUT_CYCLES        = 120000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_clear,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [15:0] weight1,
    output logic [15:0] weight2,
    output logic [15:0] input1,
    output logic [15:0] input2,
    output logic        weights_we,
    output logic        inputs_we,
    input  logic [15:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_PAYLOAD,
        S_COMMIT,
        S_TX_LOAD,
        S_TX_WAIT_BUSY,
        S_TX_WAIT_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        rx_valid_p1;
    logic        rx_take;
    logic [7:0]  opcode_q, opcode_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] pay_buf_q, pay_buf_d;
    logic [7:0]  tx_buf_q [8];
    logic [7:0]  tx_buf_d [8];
    logic [2:0]  tx_len_q, tx_len_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic        rx_clear_d, tx_start_d, weights_we_d, inputs_we_d;
    logic [7:0]  tx_data_d;
    logic [15:0] weight1_d, weight2_d, input1_d, input2_d;

`ifdef PERCEPTRON_COMM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // A level-held rx_valid yields exactly one byte: only its rising edge counts.
    assign rx_take = rx_valid && !rx_valid_p1;

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        byte_cnt_d   = byte_cnt_q;
        pay_buf_d    = pay_buf_q;
        tx_buf_d     = tx_buf_q;
        tx_len_d     = tx_len_q;
        tx_idx_d     = tx_idx_q;
        rx_clear_d   = 1'b0;
        tx_start_d   = tx_start;
        tx_data_d    = tx_data;
        weight1_d    = weight1;
        weight2_d    = weight2;
        input1_d     = input1;
        input2_d     = input2;
        weights_we_d = 1'b0;
        inputs_we_d  = 1'b0;
`ifdef PERCEPTRON_COMM_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_take) begin
                    rx_clear_d = 1'b1;
                    tx_idx_d   = 3'd0;
                    if (rx_data == OP_READ) begin
                        // Snapshot now so later weight/result changes cannot tear the reply.
                        tx_buf_d[0] = OP_READ_RESPONSE;
                        tx_buf_d[1] = weight1[15:8];
                        tx_buf_d[2] = weight1[7:0];
                        tx_buf_d[3] = weight2[15:8];
                        tx_buf_d[4] = weight2[7:0];
                        tx_buf_d[5] = result[15:8];
                        tx_buf_d[6] = result[7:0];
                        tx_len_d    = 3'd7;
                        state_d     = S_TX_LOAD;
                    end else if (rx_data == OP_WRITE_WEIGHTS || rx_data == OP_WRITE_INPUTS) begin
                        opcode_d   = rx_data;
                        byte_cnt_d = 2'd0;
`ifdef PERCEPTRON_COMM_TIMEOUT_EN
                        tmo_d      = '0;
`endif
                        state_d    = S_RX_PAYLOAD;
                    end else begin
                        tx_buf_d[0] = OP_WRITE_RESPONSE_ERR;
                        tx_len_d    = 3'd1;
                        state_d     = S_TX_LOAD;
                    end
                end
            end
            S_RX_PAYLOAD: begin
                if (rx_take) begin
                    rx_clear_d = 1'b1;
                    pay_buf_d  = {pay_buf_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PERCEPTRON_COMM_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_COMMIT;
                    end
                end
`ifdef PERCEPTRON_COMM_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tx_buf_d[0] = OP_WRITE_RESPONSE_ERR;
                    tx_len_d    = 3'd1;
                    tx_idx_d    = 3'd0;
                    state_d     = S_TX_LOAD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_COMMIT: begin
                if (opcode_q == OP_WRITE_WEIGHTS) begin
                    weight1_d    = pay_buf_q[31:16];
                    weight2_d    = pay_buf_q[15:0];
                    weights_we_d = 1'b1;
                end else begin
                    input1_d    = pay_buf_q[31:16];
                    input2_d    = pay_buf_q[15:0];
                    inputs_we_d = 1'b1;
                end
                tx_buf_d[0] = OP_WRITE_RESPONSE_OK;
                tx_len_d    = 3'd1;
                tx_idx_d    = 3'd0;
                state_d     = S_TX_LOAD;
            end
            S_TX_LOAD: begin
                tx_data_d  = tx_buf_q[tx_idx_q];
                tx_start_d = 1'b1;
                state_d    = S_TX_WAIT_BUSY;
            end
            S_TX_WAIT_BUSY: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = S_TX_WAIT_DONE;
                end
            end
            S_TX_WAIT_DONE: begin
                if (!tx_busy) begin
                    tx_idx_d = tx_idx_q + 3'd1;
                    state_d  = (tx_idx_q + 3'd1 == tx_len_q) ? S_IDLE : S_TX_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rx_valid_p1 <= 1'b0;
            opcode_q    <= '0;
            byte_cnt_q  <= '0;
            tx_len_q    <= '0;
            tx_idx_q    <= '0;
            rx_clear    <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            weight1     <= '0;
            weight2     <= '0;
            input1      <= '0;
            input2      <= '0;
            weights_we  <= 1'b0;
            inputs_we   <= 1'b0;
`ifdef PERCEPTRON_COMM_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rx_valid_p1 <= rx_valid;
            opcode_q    <= opcode_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_len_q    <= tx_len_d;
            tx_idx_q    <= tx_idx_d;
            rx_clear    <= rx_clear_d;
            tx_start    <= tx_start_d;
            tx_data     <= tx_data_d;
            weight1     <= weight1_d;
            weight2     <= weight2_d;
            input1      <= input1_d;
            input2      <= input2_d;
            weights_we  <= weights_we_d;
            inputs_we   <= inputs_we_d;
`ifdef PERCEPTRON_COMM_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Byte buffers are pure data; the byte counter and state guard their use after reset.
    always_ff @(posedge clk) begin
        pay_buf_q <= pay_buf_d;
        tx_buf_q  <= tx_buf_d;
    end

endmodule

// File: tb/tb_perceptron_comm_ctrl.sv
// Scoreboard bench for perceptron_comm_ctrl: random packets against a packet-level model,
// with a UART transmitter emulator that pops and compares every transmitted byte.
module tb_perceptron_comm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, rx_valid, tx_busy;
    logic [7:0]  rx_data;
    logic [15:0] result;
    logic        rx_clear, tx_start, weights_we, inputs_we;
    logic [7:0]  tx_data;
    logic [15:0] weight1, weight2, input1, input2;

    always #5 clk = ~clk;

    perceptron_comm_ctrl #(.TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_clear(rx_clear),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .weight1(weight1), .weight2(weight2), .input1(input1), .input2(input2),
        .weights_we(weights_we), .inputs_we(inputs_we), .result(result)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tx_cnt  = 0;
    int act_wwe = 0, act_iwe = 0, act_rxc = 0;
    int m_wwe   = 0, m_iwe   = 0, exp_rxc = 0;
    int last_raise_cyc = 0;
    logic [15:0] m_w1 = '0, m_w2 = '0, m_i1 = '0, m_i2 = '0;
    logic [7:0]  exp_q[$];
    int          start_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strobe monitor: counts pulses and checks the registers carry the model's values on each strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (weights_we) begin
                    act_wwe++;
                    check("we_weight1", 32'(weight1), 32'(m_w1));
                    check("we_weight2", 32'(weight2), 32'(m_w2));
                end
                if (inputs_we) begin
                    act_iwe++;
                    check("we_input1", 32'(input1), 32'(m_i1));
                    check("we_input2", 32'(input2), 32'(m_i2));
                end
                if (rx_clear) act_rxc++;
            end
        end
    end

    // UART transmitter emulator and scoreboard consumer.
    initial begin
        logic [7:0] cap;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                cap = tx_data;
                tx_cnt++;
                start_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, required no byte", cap);
                end else begin
                    check("tx_byte", 32'(cap), 32'(exp_q.pop_front()));
                end
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    if (tx_start) check("tx_data_hold", 32'(tx_data), 32'(cap));
                end
                tx_busy = 1'b1;
                repeat ($urandom_range(2, 5)) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        last_raise_cyc = cyc;
        exp_rxc++;
        @(negedge clk);
        check("rx_clear_pulse", 32'(rx_clear), 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic push_read();
        exp_q.push_back(8'd100);
        exp_q.push_back(m_w1[15:8]);
        exp_q.push_back(m_w1[7:0]);
        exp_q.push_back(m_w2[15:8]);
        exp_q.push_back(m_w2[7:0]);
        exp_q.push_back(result[15:8]);
        exp_q.push_back(result[7:0]);
    endtask

    task automatic check_regs();
        check("weight1", 32'(weight1), 32'(m_w1));
        check("weight2", 32'(weight2), 32'(m_w2));
        check("input1", 32'(input1), 32'(m_i1));
        check("input2", 32'(input2), 32'(m_i2));
        check("weights_we_count", act_wwe, m_wwe);
        check("inputs_we_count", act_iwe, m_iwe);
        check("rx_clear_count", act_rxc, exp_rxc);
    endtask

    // Waits for the scoreboard to drain; exp_lat < 0 skips the first-byte latency check.
    task automatic wait_resp(input int exp_lat);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tx_busy || tx_start) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_wait: %0d bytes still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        if (exp_lat >= 0) begin
            if (start_cyc_q.size() > 0) begin
                check("tx_latency", start_cyc_q[0] - last_raise_cyc, exp_lat);
            end else begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_latency: got no tx_start, required one after %0d cycles", exp_lat);
            end
        end
        start_cyc_q.delete();
    endtask

    task automatic run_packet(input logic [7:0] op, input logic [31:0] pay);
        int lat;
        if (op == 8'd5) begin
            push_read();
            lat = 2;
        end else if (op == 8'd50 || op == 8'd51) begin
            if (op == 8'd50) begin
                m_w1 = pay[31:16]; m_w2 = pay[15:0]; m_wwe++;
            end else begin
                m_i1 = pay[31:16]; m_i2 = pay[15:0]; m_iwe++;
            end
            exp_q.push_back(8'd101);
            lat = 3;
        end else begin
            exp_q.push_back(8'd102);
            lat = 2;
        end
        send_byte(op);
        if (op == 8'd5) result = 16'($urandom);
        if (op == 8'd50 || op == 8'd51) begin
            for (int i = 3; i >= 0; i--) send_byte(pay[i*8 +: 8]);
        end
        wait_resp(lat);
        check_regs();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete within cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, t, kind;
        logic [15:0] old1, old2;
        logic [7:0]  bad;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; result = 16'h0001;
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_rx_clear", 32'(rx_clear), 32'd0);
        check("rst_weights_we", 32'(weights_we), 32'd0);
        check("rst_inputs_we", 32'(inputs_we), 32'd0);
        check("rst_regs", 32'({weight1, weight2} | {input1, input2}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_packet(8'd5, 32'h0);
        run_packet(8'd50, 32'h15AAFC33);
        run_packet(8'd5, 32'h0);
        run_packet(8'd51, 32'hE000200F);
        run_packet(8'd7, 32'h0);
        run_packet(8'd5, 32'h0);

        for (int k = 0; k < 24; k++) begin
            kind = int'($urandom_range(0, 3));
            result = 16'($urandom);
            case (kind)
                0: run_packet(8'd5, 32'h0);
                1: run_packet(8'd50, $urandom);
                2: run_packet(8'd51, $urandom);
                default: begin
                    do bad = 8'($urandom); while (bad == 8'd5 || bad == 8'd50 || bad == 8'd51);
                    run_packet(bad, 32'h0);
                end
            endcase
        end

        // Reset during the 4th byte of a read response.
        result = 16'hBEEF;
        push_read();
        base = tx_cnt;
        send_byte(8'd5);
        t = 0;
        while (tx_cnt - base < 4 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("reached_4th_byte", tx_cnt - base, 4);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_weight1", 32'(weight1), 32'd0);
        check("midrst_strobes", 32'({weights_we, inputs_we, rx_clear}), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        start_cyc_q.delete();
        m_w1 = '0; m_w2 = '0; m_i1 = '0; m_i2 = '0;
        repeat (4) @(negedge clk);
        t = 0;
        while (tx_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        result = 16'h1234;
        run_packet(8'd5, 32'h0);

        // Stalled write payload.
        old1 = m_w1; old2 = m_w2;
`ifdef PERCEPTRON_COMM_TIMEOUT_EN
        exp_q.push_back(8'd102);
        send_byte(8'd50); send_byte(8'h11); send_byte(8'h22);
        wait_resp(-1);
        check("tmo_weight1_kept", 32'(weight1), 32'(old1));
        check("tmo_weight2_kept", 32'(weight2), 32'(old2));
        check_regs();
        run_packet(8'd5, 32'h0);
`else
        base = tx_cnt;
        send_byte(8'd50); send_byte(8'h11); send_byte(8'h22);
        repeat (300) @(negedge clk);
        check("stall_no_reply", tx_cnt - base, 0);
        check("stall_weight1_kept", 32'(weight1), 32'(old1));
        check("stall_weight2_kept", 32'(weight2), 32'(old2));
        m_w1 = 16'h1122; m_w2 = 16'h3344; m_wwe++;
        exp_q.push_back(8'd101);
        send_byte(8'h33); send_byte(8'h44);
        wait_resp(3);
        check_regs();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
